mult_share_arbiter: RTL and testbench

- Shares one sequential unsigned shift-add multiplier (W-bit operands, 2W+1-bit product, LAT cycles per operation) among NREQ requesters.
- Round-robin arbitration selects a requester, latches its operands, and pulses the multiplier load.
- Waits out the multiplier latency, captures the product, and returns it with the requester ID over a valid/ready result handshake.
- Sits between requester blocks and the multiplier instance; it is the only block that drives the multiplier's load and operand inputs.

---
 rtl/mult_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one sequential unsigned shift-add multiplier among NREQ requesters.
//   A round-robin scan picks a requester, latches its operands, pulses the
//   multiplier load, waits out the multiplier latency plus one settle cycle,
//   captures the product and hands it back with the requester index over a
//   valid/ready result handshake.
//
// Ports
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   req          per-requester level request, held until its gnt bit
//   a_in, b_in   packed operands, requester i at [i*W +: W]
//   gnt          one-hot, one-cycle grant when operands are taken
//   busy         high whenever the FSM is not idle
//   mul_load     one-cycle load pulse to the multiplier
//   mul_a, mul_b operands latched for the multiplier, stable per operation
//   mul_product  multiplier result (2W+1 bits)
//   res_valid / res_ready / res_id / res_data   result handshake
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 6,
  parameter int LAT  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              mul_load,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W:0]      mul_product,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_id,
  output logic [2*W:0]      res_data
);

  localparam int ID_W  = 2;
  localparam int CNT_W = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  sel;
  logic [CNT_W-1:0] cnt;

  logic [ID_W-1:0]  win;
  logic             win_found;
  logic [ID_W-1:0]  ptr_inc;

  // Round-robin scan: first set request starting at ptr, wrapping at NREQ.
  always_comb begin
    int idx;
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[idx]) begin
        win       = ID_W'(idx);
        win_found = 1'b1;
      end
    end
  end

  assign ptr_inc = (int'(sel) == NREQ - 1) ? '0 : sel + ID_W'(1);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // Operands are captured on the way into LOAD so the multiplier sees
          // them stable during the load pulse and for the whole operation.
          if (win_found) begin
            sel   <= win;
            mul_a <= a_in[int'(win)*W +: W];
            mul_b <= b_in[int'(win)*W +: W];
          end
        end
        LOAD: cnt <= '0;
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          // LAT iterations plus one settle cycle before sampling the product.
          if (cnt == LAT_C) begin
            res_data  <= mul_product;
            res_id    <= sel;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ptr       <= ptr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt == LAT_C) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    gnt      = '0;
    mul_load = 1'b0;
    busy     = (state != IDLE);
    if (state == LOAD) begin
      gnt[sel] = 1'b1;
      mul_load = 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 6;
  localparam int LAT  = 6;
  localparam int P    = 2*W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in, b_in;
  logic [NREQ-1:0]   gnt;
  logic              busy, mul_load;
  logic [W-1:0]      mul_a, mul_b;
  logic [P-1:0]      mul_product;
  logic              res_valid, res_ready;
  logic [1:0]        res_id;
  logic [P-1:0]      res_data;

  int pass_cnt = 0;
  int total    = 0;
  int viol     = 0;

  mult_share_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Shift-add multiplier: one partial product per cycle after the load pulse.
  logic [P-1:0] m_acc, m_cand;
  logic [W-1:0] m_plier;
  int           m_it;
  always @(posedge clk) begin
    if (rst) begin
      m_acc <= '0; m_cand <= '0; m_plier <= '0; m_it <= LAT;
    end else if (mul_load) begin
      m_acc <= '0; m_cand <= P'(mul_a); m_plier <= mul_b; m_it <= 0;
    end else if (m_it < LAT) begin
      if (m_plier[0]) m_acc <= m_acc + m_cand;
      m_cand  <= m_cand << 1;
      m_plier <= m_plier >> 1;
      m_it    <= m_it + 1;
    end
  end
  assign mul_product = m_acc;

  // Structural properties watched for the whole run.
  always @(negedge clk) begin
    if (!$onehot0(gnt)) viol++;
    if (mul_load != (gnt != '0)) viol++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; res_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] g, output int cyc);
    cyc = 0;
    while (gnt == '0 && cyc < 40) begin tick(); cyc++; end
    g = gnt;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 40) begin tick(); cyc++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; res_ready = 1'b1; a_in = '1; b_in = '1;
    tick();
    total++;
    if ({gnt, busy, mul_load, mul_a, mul_b} !== '0) $display("FAIL reset_ctrl: got gnt=%b busy=%b load=%b a=%0d b=%0d, expected all 0", gnt, busy, mul_load, mul_a, mul_b);
    else pass_cnt++;
    total++;
    if ({res_valid, res_id, res_data} !== '0) $display("FAIL reset_res: got valid=%b id=%0d data=%0d, expected all 0", res_valid, res_id, res_data);
    else pass_cnt++;
    rst = 1'b0; req = '0; a_in = '0; b_in = '0;
  endtask

  task automatic test_single();
    int early;
    do_reset();
    set_op(0, 5, 7); req = 4'b0001;
    tick();
    total++;
    if (gnt !== 4'b0001 || mul_load !== 1'b1) $display("FAIL single_gnt_c1: got gnt=%b load=%b, expected 0001/1", gnt, mul_load);
    else pass_cnt++;
    total++;
    if (mul_a !== 6'd5 || mul_b !== 6'd7) $display("FAIL single_operands: got %0d,%0d expected 5,7", mul_a, mul_b);
    else pass_cnt++;
    req = '0;
    early = 0;
    for (int c = 2; c <= 8; c++) begin tick(); if (res_valid) early++; end
    total++;
    if (early != 0) $display("FAIL single_early_valid: got %0d early cycles expected 0", early);
    else pass_cnt++;
    tick();
    total++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== P'(35)) $display("FAIL single_result_c9: got v=%b id=%0d data=%0d expected 1/0/35", res_valid, res_id, res_data);
    else pass_cnt++;
    tick();
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) $display("FAIL single_idle_c10: got busy=%b v=%b expected 0/0", busy, res_valid);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] g;
    int cg, cv;
    int order [5] = '{0, 1, 2, 3, 0};
    int prod  [4] = '{2, 12, 30, 56};
    do_reset();
    set_op(0, 1, 2); set_op(1, 3, 4); set_op(2, 5, 6); set_op(3, 7, 8);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g, cg);
      total++;
      if (g !== NREQ'(1 << order[k])) $display("FAIL fair_grant_%0d: got %b expected %b", k, g, NREQ'(1 << order[k]));
      else pass_cnt++;
      if (k > 0) begin
        total++;
        if (cg != 2) $display("FAIL fair_gap_%0d: got %0d cycles DONE->gnt expected 2", k, cg);
        else pass_cnt++;
      end
      tick();
      total++;
      if (gnt !== '0) $display("FAIL fair_gnt_width_%0d: got %b expected 0000", k, gnt);
      else pass_cnt++;
      wait_valid(cv);
      total++;
      if (cv != 7 || res_id !== 2'(order[k]) || res_data !== P'(prod[order[k]])) $display("FAIL fair_result_%0d: got lat=%0d id=%0d data=%0d expected 7/%0d/%0d", k, cv, res_id, res_data, order[k], prod[order[k]]);
      else pass_cnt++;
    end
    req = '0;
    tick();
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] g;
    int c;
    do_reset();
    set_op(2, 2, 3); set_op(0, 4, 5);
    req = 4'b0100;
    wait_gnt(g, c);
    req = '0;
    wait_valid(c);
    total++;
    if (g !== 4'b0100 || res_data !== P'(6)) $display("FAIL rot_first: got gnt=%b data=%0d expected 0100/6", g, res_data);
    else pass_cnt++;
    req = 4'b0101;
    wait_gnt(g, c);
    req = 4'b0100;
    total++;
    if (g !== 4'b0001) $display("FAIL rot_wrap_grant: got %b expected 0001", g);
    else pass_cnt++;
    wait_valid(c);
    total++;
    if (res_id !== 2'd0 || res_data !== P'(20)) $display("FAIL rot_wrap_result: got id=%0d data=%0d expected 0/20", res_id, res_data);
    else pass_cnt++;
    wait_gnt(g, c);
    req = '0;
    total++;
    if (g !== 4'b0100) $display("FAIL rot_second_grant: got %b expected 0100", g);
    else pass_cnt++;
    wait_valid(c);
    tick();
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] g;
    int c, bad;
    do_reset();
    res_ready = 1'b0;
    set_op(1, 63, 63); set_op(3, 2, 2);
    req = 4'b0010;
    wait_gnt(g, c);
    req = 4'b1000;
    wait_valid(c);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (res_valid !== 1'b1 || res_data !== P'(3969) || res_id !== 2'd1 || gnt !== '0) bad++;
      tick();
    end
    total++;
    if (bad != 0) $display("FAIL bp_hold: got %0d bad stall cycles expected 0", bad);
    else pass_cnt++;
    total++;
    if (res_valid !== 1'b1 || res_data !== P'(3969)) $display("FAIL bp_still_valid: got v=%b data=%0d expected 1/3969", res_valid, res_data);
    else pass_cnt++;
    res_ready = 1'b1;
    tick();
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_accept: got v=%b busy=%b expected 0/0", res_valid, busy);
    else pass_cnt++;
    tick();
    total++;
    if (gnt !== 4'b1000) $display("FAIL bp_pending_grant: got %b expected 1000", gnt);
    else pass_cnt++;
    req = '0;
  endtask

  task automatic test_reset_midop();
    logic [NREQ-1:0] g;
    int c, seen;
    do_reset();
    set_op(0, 1, 1); set_op(3, 5, 5);
    req = 4'b0001;
    wait_gnt(g, c);
    req = '0;
    wait_valid(c);
    tick();
    req = 4'b1000;
    wait_gnt(g, c);
    req = '0;
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (busy !== 1'b1 || res_valid !== 1'b0) $display("FAIL midop_running: got busy=%b v=%b expected 1/0", busy, res_valid);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({gnt, busy, mul_load, mul_a, mul_b, res_valid, res_id, res_data} !== '0) $display("FAIL midop_cleared: got gnt=%b busy=%b v=%b a=%0d data=%0d expected all 0", gnt, busy, res_valid, mul_a, res_data);
    else pass_cnt++;
    seen = 0;
    for (int k = 0; k < 15; k++) begin tick(); if (res_valid) seen++; end
    total++;
    if (seen != 0) $display("FAIL midop_no_result: got %0d valid cycles expected 0", seen);
    else pass_cnt++;
    set_op(0, 2, 3); set_op(1, 3, 3);
    req = 4'b0011;
    wait_gnt(g, c);
    req = 4'b0010;
    total++;
    if (g !== 4'b0001) $display("FAIL midop_ptr_zero: got %b expected 0001", g);
    else pass_cnt++;
    wait_valid(c);
    wait_gnt(g, c);
    req = '0;
    total++;
    if (g !== 4'b0010) $display("FAIL midop_req1_grant: got %b expected 0010", g);
    else pass_cnt++;
    wait_valid(c);
    total++;
    if (res_id !== 2'd1 || res_data !== P'(9)) $display("FAIL midop_req1_result: got id=%0d data=%0d expected 1/9", res_id, res_data);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_operand_isolation();
    logic [NREQ-1:0] g;
    int c, bad;
    do_reset();
    set_op(0, 9, 11);
    req = 4'b0001;
    wait_gnt(g, c);
    req = '0;
    tick();
    a_in = '1; b_in = '1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (mul_a !== 6'd9 || mul_b !== 6'd11) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL iso_operands: got %0d changed cycles (a=%0d b=%0d) expected 0", bad, mul_a, mul_b);
    else pass_cnt++;
    wait_valid(c);
    total++;
    if (res_data !== P'(99) || res_id !== 2'd0) $display("FAIL iso_result: got id=%0d data=%0d expected 0/99", res_id, res_data);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; res_ready = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_rotation();
    test_backpressure();
    test_reset_midop();
    test_operand_isolation();
    total++;
    if (viol != 0) $display("FAIL gnt_onehot_load: got %0d violations expected 0", viol);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
